// File: rtl/register_file.sv
// ============================================================================
// register_file : 32 x 32-bit MIPS register file, two combinational read ports,
//                 one clocked write port, r0 hardwired to zero.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module register_file (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rw,
   input  logic        reg_wr,
   input  logic [31:0] bus_w,
   output logic [31:0] bus_a,
   output logic [31:0] bus_b
);

   localparam int NUM_REGS = 32;

   // r0 has no storage, so the array and the decoder start at index 1
   logic [31:0] regs [1:NUM_REGS-1];
   logic [NUM_REGS-1:1] wr_sel;

   always_comb begin
      wr_sel = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         wr_sel[i] = reg_wr && (rw == 5'(i));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_sel[i]) begin
               regs[i] <= bus_w;
            end
         end
      end
   end

   // Address 0 (or an unknown address) matches no entry and reads as zero
   always_comb begin
      bus_a = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (rs == 5'(i)) begin
            bus_a = regs[i];
         end
      end
   end

   always_comb begin
      bus_b = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (rt == 5'(i)) begin
            bus_b = regs[i];
         end
      end
   end

endmodule

`default_nettype wire
